// File: rtl/tmr_scrub_reg.sv
// Triple-redundant register bank with bitwise majority-voted output.
// Copy disagreements are repaired by a scrub write and counted in a saturating counter.
module tmr_scrub_reg #(
    parameter int unsigned      WIDTH        = 8,
    parameter int unsigned      CNT_W        = 16,
    parameter int unsigned      SCRUB_PERIOD = 0,
    parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    input  logic             inj_en,
    input  logic [1:0]       inj_sel,
    input  logic [WIDTH-1:0] inj_mask,
    output logic             mismatch,
    output logic             err_sticky,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_count
);

    logic [WIDTH-1:0] c0_q, c1_q, c2_q;
    logic [WIDTH-1:0] c0_d, c1_d, c2_d;
    logic [WIDTH-1:0] voteVal;
    logic [CNT_W-1:0] errCount_q, errCount_d;
    logic             errSticky_q, errSticky_d;
    logic             scrubDue;
    logic             corrEvent;

    assign voteVal    = (c0_q & c1_q) | (c1_q & c2_q) | (c0_q & c2_q);
    assign q          = voteVal;
    assign mismatch   = |((c0_q ^ c1_q) | (c1_q ^ c2_q));
    assign err_count  = errCount_q;
    assign err_sticky = errSticky_q;

    generate
        if (SCRUB_PERIOD > 0) begin : gPeriodic
            // Free-running phase counter; scrubbing is allowed only on its last phase.
            localparam int unsigned    PW   = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
            localparam logic [PW-1:0]  LAST = PW'(SCRUB_PERIOD - 1);
            logic [PW-1:0] pcnt_q, pcnt_d;

            assign scrubDue = (pcnt_q == LAST);
            assign pcnt_d   = scrubDue ? '0 : pcnt_q + PW'(1);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pcnt_q <= '0;
                end else begin
                    pcnt_q <= pcnt_d;
                end
            end
        end else begin : gImmediate
            assign scrubDue = 1'b1;
        end
    endgenerate

    // Load beats injection, and both suppress scrubbing for the cycle.
    always_comb begin
        c0_d      = c0_q;
        c1_d      = c1_q;
        c2_d      = c2_q;
        corrEvent = 1'b0;
        if (load) begin
            c0_d = d;
            c1_d = d;
            c2_d = d;
        end else if (inj_en) begin
            case (inj_sel)
                2'd0:    c0_d = c0_q ^ inj_mask;
                2'd1:    c1_d = c1_q ^ inj_mask;
                2'd2:    c2_d = c2_q ^ inj_mask;
                default: ;
            endcase
        end else if (scrubDue && mismatch) begin
            c0_d      = voteVal;
            c1_d      = voteVal;
            c2_d      = voteVal;
            corrEvent = 1'b1;
        end
    end

    // A correction coinciding with a clear restarts the count at one so the event survives.
    always_comb begin
        errCount_d  = errCount_q;
        errSticky_d = errSticky_q;
        if (corrEvent) begin
            errSticky_d = 1'b1;
            if (err_clr) begin
                errCount_d = CNT_W'(1);
            end else if (errCount_q != '1) begin
                errCount_d = errCount_q + CNT_W'(1);
            end
        end else if (err_clr) begin
            errCount_d  = '0;
            errSticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c0_q        <= RESET_VAL;
            c1_q        <= RESET_VAL;
            c2_q        <= RESET_VAL;
            errCount_q  <= '0;
            errSticky_q <= 1'b0;
        end else begin
            c0_q        <= c0_d;
            c1_q        <= c1_d;
            c2_q        <= c2_d;
            errCount_q  <= errCount_d;
            errSticky_q <= errSticky_d;
        end
    end

endmodule

// File: tb/tb_tmr_scrub_reg.sv
// Bench for tmr_scrub_reg: three instances (immediate scrub, period-4 scrub, 2-bit counter)
// share one stimulus stream and are checked against a bench model and hand-computed values.
module tb_tmr_scrub_reg;

    localparam int PER[3]  = '{0, 4, 0};
    localparam int CMAX[3] = '{65535, 65535, 3};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic       inj_en = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] d = 8'h00;
    logic [7:0] inj_mask = 8'h00;
    logic [1:0] inj_sel = 2'd0;

    logic [7:0]  q0, q1, q2;
    logic        mm0, mm1, mm2, st0, st1, st2;
    logic [15:0] cnt0, cnt1;
    logic [1:0]  cnt2;

    logic [7:0]  qA[3];
    logic        mmA[3];
    logic        stA[3];
    logic [15:0] cntA[3];

    assign qA[0] = q0;  assign qA[1] = q1;  assign qA[2] = q2;
    assign mmA[0] = mm0; assign mmA[1] = mm1; assign mmA[2] = mm2;
    assign stA[0] = st0; assign stA[1] = st1; assign stA[2] = st2;
    assign cntA[0] = cnt0; assign cntA[1] = cnt1; assign cntA[2] = {14'b0, cnt2};

    int nCompared = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    tmr_scrub_reg #(.WIDTH(8), .CNT_W(16), .SCRUB_PERIOD(0), .RESET_VAL(8'h00)) dut0 (
        .clk(clk), .rst(rst), .load(load), .d(d), .q(q0), .inj_en(inj_en),
        .inj_sel(inj_sel), .inj_mask(inj_mask), .mismatch(mm0), .err_sticky(st0),
        .err_clr(err_clr), .err_count(cnt0));

    tmr_scrub_reg #(.WIDTH(8), .CNT_W(16), .SCRUB_PERIOD(4), .RESET_VAL(8'h00)) dut1 (
        .clk(clk), .rst(rst), .load(load), .d(d), .q(q1), .inj_en(inj_en),
        .inj_sel(inj_sel), .inj_mask(inj_mask), .mismatch(mm1), .err_sticky(st1),
        .err_clr(err_clr), .err_count(cnt1));

    tmr_scrub_reg #(.WIDTH(8), .CNT_W(2), .SCRUB_PERIOD(0), .RESET_VAL(8'h00)) dut2 (
        .clk(clk), .rst(rst), .load(load), .d(d), .q(q2), .inj_en(inj_en),
        .inj_sel(inj_sel), .inj_mask(inj_mask), .mismatch(mm2), .err_sticky(st2),
        .err_clr(err_clr), .err_count(cnt2));

    // Model state: three copies per instance, phase, count and sticky flag.
    logic [7:0] mc[3][3];
    int         mp[3];
    int         mcnt[3];
    bit         mst[3];
    bit         due, differ, corr;

    function automatic logic [7:0] majority(logic [7:0] a, logic [7:0] b, logic [7:0] c);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) begin
            r[k] = (int'(a[k]) + int'(b[k]) + int'(c[k])) >= 2;
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) mc[i][j] <= 8'h00;
                mp[i]   <= 0;
                mcnt[i] <= 0;
                mst[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                due    = (PER[i] == 0) || (mp[i] == PER[i] - 1);
                differ = (mc[i][0] != mc[i][1]) || (mc[i][1] != mc[i][2]);
                corr   = 1'b0;
                if (load) begin
                    for (int j = 0; j < 3; j++) mc[i][j] <= d;
                end else if (inj_en) begin
                    if (int'(inj_sel) < 3) mc[i][int'(inj_sel)] <= mc[i][int'(inj_sel)] ^ inj_mask;
                end else if (due && differ) begin
                    for (int j = 0; j < 3; j++) mc[i][j] <= majority(mc[i][0], mc[i][1], mc[i][2]);
                    corr = 1'b1;
                end
                if (PER[i] > 0) mp[i] <= (mp[i] + 1) % PER[i];
                if (corr) begin
                    mst[i]  <= 1'b1;
                    mcnt[i] <= err_clr ? 1 : ((mcnt[i] < CMAX[i]) ? mcnt[i] + 1 : mcnt[i]);
                end else if (err_clr) begin
                    mcnt[i] <= 0;
                    mst[i]  <= 1'b0;
                end
            end
        end
    end

    task automatic checkModel();
        logic [7:0] eq;
        bit         em;
        for (int i = 0; i < 3; i++) begin
            eq = majority(mc[i][0], mc[i][1], mc[i][2]);
            em = (mc[i][0] != mc[i][1]) || (mc[i][1] != mc[i][2]);
            nCompared++;
            if (qA[i] !== eq || mmA[i] !== em || cntA[i] !== 16'(mcnt[i]) || stA[i] !== mst[i]) begin
                nMismatched++;
                $display("[TB] FAIL model dut%0d @%0t: got q=%h mm=%0d cnt=%0d st=%0d, want q=%h mm=%0d cnt=%0d st=%0d",
                         i, $time, qA[i], mmA[i], cntA[i], stA[i], eq, em, mcnt[i], mst[i]);
            end
        end
    endtask

    // One clock edge with the given inputs, then the per-cycle model comparison.
    task automatic applyStimulus(input bit ld, input logic [7:0] dv, input bit ie,
                                 input logic [1:0] sel, input logic [7:0] mask, input bit clr);
        load     = ld;
        d        = dv;
        inj_en   = ie;
        inj_sel  = sel;
        inj_mask = mask;
        err_clr  = clr;
        @(posedge clk);
        #1;
        checkModel();
    endtask

    task automatic checkOutput(input string name, input int i, input logic [7:0] eq,
                               input bit em, input int ec, input bit es);
        nCompared++;
        if (qA[i] !== eq || mmA[i] !== em || cntA[i] !== 16'(ec) || stA[i] !== es) begin
            nMismatched++;
            $display("[TB] FAIL %s dut%0d: got q=%h mm=%0d cnt=%0d st=%0d, want q=%h mm=%0d cnt=%0d st=%0d",
                     name, i, qA[i], mmA[i], cntA[i], stA[i], eq, em, ec, es);
        end
        if (!rst) begin
            nCompared++;
            if (majority(mc[i][0], mc[i][1], mc[i][2]) !== eq || mcnt[i] != ec || mst[i] != es) begin
                nMismatched++;
                $display("[TB] FAIL %s model%0d: got q=%h cnt=%0d st=%0d, want q=%h cnt=%0d st=%0d",
                         name, i, majority(mc[i][0], mc[i][1], mc[i][2]), mcnt[i], mst[i], eq, ec, es);
            end
        end
    endtask

    task automatic checkAll(input string name, input logic [7:0] eq, input bit em,
                            input int ec, input bit es);
        for (int i = 0; i < 3; i++) checkOutput(name, i, eq, em, ec, es);
    endtask

    initial begin
        #1 rst = 1'b1;
        #11;
        checkAll("reset", 8'h00, 1'b0, 0, 1'b0);
        #10 rst = 1'b0;

        applyStimulus(1, 8'hA5, 0, 2'd0, 8'h00, 0);
        checkAll("load_a5", 8'hA5, 1'b0, 0, 1'b0);
        applyStimulus(0, 8'h00, 1, 2'd1, 8'h0F, 0);
        checkAll("inject_c1", 8'hA5, 1'b1, 0, 1'b0);
        applyStimulus(0, 8'h00, 0, 2'd0, 8'h00, 0);
        checkOutput("scrub_now", 0, 8'hA5, 1'b0, 1, 1'b1);
        checkOutput("scrub_wait", 1, 8'hA5, 1'b1, 0, 1'b0);
        checkOutput("scrub_now", 2, 8'hA5, 1'b0, 1, 1'b1);
        applyStimulus(0, 8'h00, 0, 2'd0, 8'h00, 0);
        checkOutput("scrub_period", 1, 8'hA5, 1'b0, 1, 1'b1);

        applyStimulus(0, 8'h00, 1, 2'd0, 8'h80, 0);
        checkOutput("inj_pcnt0", 1, 8'hA5, 1'b1, 1, 1'b1);
        applyStimulus(0, 8'h00, 0, 2'd0, 8'h00, 0);
        checkOutput("second_scrub", 0, 8'hA5, 1'b0, 2, 1'b1);
        checkOutput("hold_1", 1, 8'hA5, 1'b1, 1, 1'b1);
        applyStimulus(0, 8'h00, 0, 2'd0, 8'h00, 0);
        checkOutput("hold_2", 1, 8'hA5, 1'b1, 1, 1'b1);
        applyStimulus(0, 8'h00, 0, 2'd0, 8'h00, 0);
        checkOutput("pcnt3_scrub", 1, 8'hA5, 1'b0, 2, 1'b1);

        applyStimulus(0, 8'h00, 1, 2'd0, 8'h01, 0);
        applyStimulus(0, 8'h00, 1, 2'd2, 8'h01, 0);
        checkOutput("two_copy_vote", 0, 8'hA4, 1'b1, 2, 1'b1);
        applyStimulus(0, 8'h00, 0, 2'd0, 8'h00, 0);
        checkOutput("two_copy_commit", 0, 8'hA4, 1'b0, 3, 1'b1);
        checkOutput("two_copy_pending", 1, 8'hA4, 1'b1, 2, 1'b1);
        checkOutput("sat_reached", 2, 8'hA4, 1'b0, 3, 1'b1);
        applyStimulus(0, 8'h00, 0, 2'd0, 8'h00, 0);
        checkOutput("two_copy_commit", 1, 8'hA4, 1'b0, 3, 1'b1);

        applyStimulus(0, 8'h00, 1, 2'd1, 8'hFF, 0);
        applyStimulus(1, 8'h3C, 0, 2'd0, 8'h00, 0);
        checkOutput("load_over_fault", 0, 8'h3C, 1'b0, 3, 1'b1);
        checkOutput("load_over_fault", 1, 8'h3C, 1'b0, 3, 1'b1);

        for (int n = 0; n < 2; n++) begin
            applyStimulus(0, 8'h00, 1, 2'd2, 8'h01, 0);
            applyStimulus(0, 8'h00, 0, 2'd0, 8'h00, 0);
        end
        checkOutput("count_5", 0, 8'h3C, 1'b0, 5, 1'b1);
        checkOutput("count_deferred", 1, 8'h3C, 1'b1, 4, 1'b1);
        checkOutput("saturated", 2, 8'h3C, 1'b0, 3, 1'b1);

        applyStimulus(0, 8'h00, 1, 2'd0, 8'h02, 0);
        applyStimulus(0, 8'h00, 0, 2'd0, 8'h00, 1);
        checkAll("clr_on_corr", 8'h3C, 1'b0, 1, 1'b1);
        applyStimulus(0, 8'h00, 0, 2'd0, 8'h00, 1);
        checkAll("clr_plain", 8'h3C, 1'b0, 0, 1'b0);

        applyStimulus(0, 8'h00, 1, 2'd1, 8'h55, 0);
        #3 rst = 1'b1;
        #1;
        checkAll("async_reset", 8'h00, 1'b0, 0, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;

        applyStimulus(1, 8'h5A, 0, 2'd0, 8'h00, 0);
        checkAll("load_after_rst", 8'h5A, 1'b0, 0, 1'b0);
        applyStimulus(0, 8'h00, 1, 2'd0, 8'h01, 0);
        applyStimulus(0, 8'h00, 0, 2'd0, 8'h00, 0);
        checkOutput("pcnt_restart", 1, 8'h5A, 1'b1, 0, 1'b0);
        applyStimulus(0, 8'h00, 0, 2'd0, 8'h00, 0);
        checkOutput("pcnt_restart_scrub", 1, 8'h5A, 1'b0, 1, 1'b1);

        applyStimulus(0, 8'h00, 1, 2'd1, 8'h10, 0);
        applyStimulus(0, 8'h00, 1, 2'd3, 8'hFF, 0);
        checkOutput("sel3_blocks", 0, 8'h5A, 1'b1, 1, 1'b1);
        applyStimulus(0, 8'h00, 0, 2'd0, 8'h00, 0);
        checkOutput("sel3_after", 0, 8'h5A, 1'b0, 2, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
